// File: rtl/uart_pkg.sv
// Shared UART definitions: legacy TX bit-engine state codes, the TX buffer
// launch FSM states, the missed-strobe timeout and a parity helper.
package uart_pkg;

    // Bit-level transmitter state codes used by the existing UART TX engine.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } uart_tx_state_e;

    // Launch FSM of the TX buffer.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } buf_state_e;

    // Cycles the buffer waits for Busy before assuming the TX stage missed
    // the strobe and treating the byte as sent.
    localparam int TIMEOUT = 4;
    localparam int TIMER_W = 2;

    // Even parity of a data byte, shared with the bit engine.
    function automatic logic parity_even(input logic [7:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart_tx_buffer_if.sv
// Handshake between the TX buffer (master) and the UART TX stage (slave).
interface uart_tx_buffer_if;
    logic [7:0] P_DATA;
    logic       DATA_VALID;
    logic       Busy;

    modport master (output P_DATA, output DATA_VALID, input Busy);
    modport slave  (input P_DATA, input DATA_VALID, output Busy);
endinterface

// File: rtl/uart_fifo_mem.sv
// DEPTH x 8 byte storage with one write port and one read port. Pointers wrap
// naturally because DEPTH is a power of two. Storage carries no reset.
module uart_fifo_mem #(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic [7:0] rd_data
);

    localparam logic [AW-1:0] PTR_ZERO = {AW{1'b0}};
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [7:0]    mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;

    // Write and read pointers advance on each accepted push / pop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
        end else begin
            if (push) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
        end
    end

    // Byte storage: written at the write pointer, never reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    assign rd_data = mem_r[rd_ptr_r];

endmodule

// File: rtl/uart_tx_buffer.sv
// Host-side byte FIFO feeding a UART TX stage. Each buffered byte is presented
// on P_DATA with a one-cycle DATA_VALID strobe, then the FSM waits for the TX
// stage to go busy and idle again (or times out if Busy never rises).
module uart_tx_buffer
    import uart_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [7:0]       wr_data,
    input  logic             clr_ovf,
    uart_tx_buffer_if.master tx,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count,
    output logic             overflow
);

    localparam logic [CNT_W-1:0]   CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]   CNT_FULL  = CNT_W'(DEPTH);
    localparam logic [TIMER_W-1:0] TMR_ZERO  = {TIMER_W{1'b0}};
    localparam logic [TIMER_W-1:0] TMR_ONE   = TIMER_W'(1);
    localparam logic [TIMER_W-1:0] TMR_LAST  = TIMER_W'(TIMEOUT - 1);

    buf_state_e         state_r;
    logic [TIMER_W-1:0] timer_r;
    logic [7:0]         p_data_r;
    logic               data_valid_r;
    logic [CNT_W-1:0]   count_r;
    logic               full_r;
    logic               empty_r;
    logic               overflow_r;

    logic               push_s;
    logic               pop_s;
    logic [7:0]         rd_data_s;
    logic [CNT_W-1:0]   count_next_s;

    uart_fifo_mem #(.DEPTH(DEPTH)) u_mem (
        .clk       (clk),
        .reset     (reset),
        .push      (push_s),
        .push_data (wr_data),
        .pop       (pop_s),
        .rd_data   (rd_data_s)
    );

    // Accept writes only when not full; pop only from IDLE with data and an idle TX.
    always_comb begin
        push_s       = wr_en & ~full_r;
        pop_s        = (state_r == IDLE) & ~empty_r & ~tx.Busy;
        count_next_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + CNT_ONE;
            2'b01:   count_next_s = count_r - CNT_ONE;
            default: count_next_s = count_r;
        endcase
    end

    // Occupancy count and registered full/empty flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_r <= CNT_ZERO;
            full_r  <= 1'b0;
            empty_r <= 1'b1;
        end else begin
            count_r <= count_next_s;
            full_r  <= (count_next_s == CNT_FULL);
            empty_r <= (count_next_s == CNT_ZERO);
        end
    end

    // Sticky overflow: a dropped write wins over a same-cycle clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow_r <= 1'b0;
        end else if (wr_en && full_r) begin
            overflow_r <= 1'b1;
        end else if (clr_ovf) begin
            overflow_r <= 1'b0;
        end else begin
            overflow_r <= overflow_r;
        end
    end

    // Launch FSM with registered P_DATA / DATA_VALID.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= IDLE;
            timer_r      <= TMR_ZERO;
            p_data_r     <= 8'h00;
            data_valid_r <= 1'b0;
        end else begin
            data_valid_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (pop_s) begin
                        state_r      <= LAUNCH;
                        p_data_r     <= rd_data_s;
                        data_valid_r <= 1'b1;
                    end
                end
                LAUNCH: begin
                    state_r <= WAIT_BUSY;
                    timer_r <= TMR_ZERO;
                end
                WAIT_BUSY: begin
                    if (tx.Busy) begin
                        state_r <= WAIT_DONE;
                    end else if (timer_r == TMR_LAST) begin
                        // TX never picked up the strobe; count byte as sent.
                        state_r <= IDLE;
                    end else begin
                        timer_r <= timer_r + TMR_ONE;
                    end
                end
                WAIT_DONE: begin
                    if (!tx.Busy) begin
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign tx.P_DATA     = p_data_r;
    assign tx.DATA_VALID = data_valid_r;
    assign full          = full_r;
    assign empty         = empty_r;
    assign count         = count_r;
    assign overflow      = overflow_r;

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Directed bench for uart_tx_buffer with a behavioural TX-stage model and a
// byte scoreboard checked on every DATA_VALID strobe.
module tb_uart_tx_buffer;

    localparam int DEPTH = 8;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             wr_en;
    logic [7:0]       wr_data;
    logic             clr_ovf;
    logic             full;
    logic             empty;
    logic             overflow;
    logic [CNT_W-1:0] count;

    uart_tx_buffer_if bif ();

    int total = 0;
    int bad   = 0;

    // TX model control: 0 = Busy one cycle after strobe for busy_len cycles,
    // 1 = never busy, 2 = held busy.
    int tx_mode  = 2;
    int busy_len = 3;
    int launches = 0;
    int cyc      = 0;
    int last_cyc = 0;
    int prev_cyc = 0;
    logic [7:0] exp_q [$];

    uart_tx_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .clr_ovf  (clr_ovf),
        .tx       (bif),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_write(input logic [7:0] b, input bit stored);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_data = b;
        if (stored) exp_q.push_back(b);
        @(posedge clk);
        #2;
        wr_en = 1'b0;
    endtask

    task automatic wait_launches(input int target, input int budget);
        int n;
        n = 0;
        while (launches < target && n < budget) begin
            tick();
            n++;
        end
        check("launch_wait", 32'(launches >= target), 32'd1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_dv"},    32'(bif.DATA_VALID), 32'd0);
        check({tag, "_pdata"}, 32'(bif.P_DATA),     32'h00);
        check({tag, "_count"}, 32'(count),          32'd0);
        check({tag, "_empty"}, 32'(empty),          32'd1);
        check({tag, "_full"},  32'(full),           32'd0);
        check({tag, "_ovf"},   32'(overflow),       32'd0);
    endtask

    // TX stage model and scoreboard consumer, sampling 1 ns after each edge.
    initial begin
        logic [7:0] e;
        bit start_pend;
        int bcnt;
        start_pend = 1'b0;
        bcnt       = 0;
        bif.Busy   = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            case (tx_mode)
                2: begin bif.Busy = 1'b1; start_pend = 1'b0; bcnt = 0; end
                1: begin bif.Busy = 1'b0; start_pend = 1'b0; bcnt = 0; end
                default: begin
                    if (start_pend) begin
                        bif.Busy   = 1'b1;
                        bcnt       = busy_len;
                        start_pend = 1'b0;
                    end else if (bcnt > 0) begin
                        bcnt--;
                        if (bcnt == 0) bif.Busy = 1'b0;
                    end else begin
                        bif.Busy = 1'b0;
                    end
                end
            endcase
            if (bif.DATA_VALID === 1'b1) begin
                launches++;
                prev_cyc = last_cyc;
                last_cyc = cyc;
                check("launch_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("launch_byte", 32'(bif.P_DATA), 32'(e));
                end
                if (tx_mode == 0) start_pend = 1'b1;
            end
        end
    end

    // Directed stimulus sequence.
    initial begin
        int base;
        reset   = 1'b0;
        wr_en   = 1'b0;
        wr_data = 8'h00;
        clr_ovf = 1'b0;
        repeat (2) tick();
        check_reset_values("por");
        @(negedge clk);
        reset   = 1'b1;
        tx_mode = 0;
        repeat (2) tick();

        // Single byte into empty FIFO.
        busy_len = 3;
        do_write(8'hA5, 1'b1);
        check("t1_count_store", 32'(count), 32'd1);
        check("t1_empty_store", 32'(empty), 32'd0);
        tick();
        check("t1_dv",    32'(bif.DATA_VALID), 32'd1);
        check("t1_pdata", 32'(bif.P_DATA),     32'hA5);
        check("t1_count", 32'(count),          32'd0);
        check("t1_empty", 32'(empty),          32'd1);
        tick();
        check("t1_dv_one_cycle", 32'(bif.DATA_VALID), 32'd0);
        wait_launches(1, 50);
        repeat (10) tick();
        check("t1_pdata_hold", 32'(bif.P_DATA), 32'hA5);

        // Fill while TX is busy, overflow handling, then drain in order.
        tx_mode = 2;
        repeat (2) tick();
        base = launches;
        for (int i = 1; i <= 7; i++) do_write(8'(i), 1'b1);
        check("t2_full_at7",  32'(full),  32'd0);
        check("t2_count_at7", 32'(count), 32'd7);
        do_write(8'h08, 1'b1);
        check("t2_full_at8",  32'(full),  32'd1);
        check("t2_count_at8", 32'(count), 32'd8);
        repeat (2) tick();
        check("t2_busy_blocks", 32'(launches), 32'(base));
        do_write(8'hFF, 1'b0);
        check("t2_ovf_set",     32'(overflow), 32'd1);
        check("t2_count_drop",  32'(count),    32'd8);
        repeat (2) tick();
        check("t2_ovf_sticky",  32'(overflow), 32'd1);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_data = 8'hFF;
        clr_ovf = 1'b1;
        tick();
        wr_en   = 1'b0;
        clr_ovf = 1'b0;
        check("t2_ovf_clr_vs_set", 32'(overflow), 32'd1);
        @(negedge clk);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        check("t2_ovf_cleared", 32'(overflow), 32'd0);
        busy_len = 10;
        tx_mode  = 0;
        wait_launches(base + 8, 400);
        check("t2_all_drained", 32'(exp_q.size()), 32'd0);
        repeat (15) tick();
        check("t2_empty", 32'(empty), 32'd1);

        // TX never raises Busy: timeout back to IDLE, next byte launched.
        tx_mode = 1;
        repeat (2) tick();
        base = launches;
        do_write(8'h11, 1'b1);
        do_write(8'h22, 1'b1);
        wait_launches(base + 2, 60);
        check("t3_timeout_gap", 32'(last_cyc - prev_cyc), 32'd6);
        repeat (8) tick();
        check("t3_count", 32'(count), 32'd0);

        // Reset while waiting for TX done.
        tx_mode  = 0;
        busy_len = 10;
        repeat (2) tick();
        base = launches;
        do_write(8'hC1, 1'b1);
        check("t4_count_c1", 32'(count), 32'd1);
        do_write(8'hC2, 1'b1);
        check("t4_push_pop_count", 32'(count), 32'd1);
        do_write(8'hC3, 1'b1);
        check("t4_count_c3", 32'(count), 32'd2);
        wait_launches(base + 1, 20);
        repeat (3) tick();
        check("t4_count_wait_done", 32'(count), 32'd2);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_reset_values("t4_async");
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        base  = launches;
        repeat (30) tick();
        check("t4_no_launch_after_reset", 32'(launches), 32'(base));
        check("t4_empty", 32'(empty), 32'd1);

        // Twenty bytes with concurrent writes and pops, wrapping pointers.
        busy_len = 2;
        base     = launches;
        for (int i = 0; i < 20; i++) begin
            do_write(8'(i * 37 + 5), 1'b1);
            repeat (2 + (i % 3)) tick();
        end
        wait_launches(base + 20, 300);
        check("t5_all_drained", 32'(exp_q.size()), 32'd0);
        check("t5_no_overflow", 32'(overflow),     32'd0);
        repeat (10) tick();
        check("t5_empty", 32'(empty), 32'd1);
        check("t5_launch_count", 32'(launches - base), 32'd20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
